// File: rtl/fake_n64_controller_rx.sv
// Console-facing Joybus receiver: decodes pulse-width bits into command, address and WRITE CRC,
// then lends the line to the transmitter until it toggles rx_handoff.
module fake_n64_controller_rx #(
  parameter int unsigned LEVEL_WIDTH  = 2,
  parameter int unsigned BIT_WIDTH    = 4 * LEVEL_WIDTH,
  parameter int unsigned IDLE_TIMEOUT = 2 * BIT_WIDTH,
  parameter int unsigned LOW_TIMEOUT  = 4 * BIT_WIDTH
) (
  input  logic        sample_clk,
  input  logic        reset_n,
  input  logic        data_rx,
  input  logic        rx_handoff,
  output logic        cur_operation,
  output logic [7:0]  cmd,
  output logic [15:0] address,
  output logic [7:0]  crc,
  output logic        frame_error
);

  localparam int unsigned CNT_MAX = (LOW_TIMEOUT > IDLE_TIMEOUT) ? LOW_TIMEOUT : IDLE_TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] LVL2    = CNT_W'(2 * LEVEL_WIDTH);
  localparam logic [CNT_W-1:0] LOW_TO  = CNT_W'(LOW_TIMEOUT);
  localparam logic [CNT_W-1:0] IDLE_TO = CNT_W'(IDLE_TIMEOUT);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_DRAIN,
    ST_ERROR,
    ST_HANDOFF
  } state_t;

  state_t           state_q;
  logic             sync1_q, s_rx_q, s_prev_q;
  logic             hs1_q, hs2_q, hcopy_q;
  logic [CNT_W-1:0] low_cnt_q, high_cnt_q;
  logic [8:0]       bit_cnt_q, exp_len_q;
  logic [6:0]       cmd_sh_q;
  logic             cur_op_q, frame_error_q;
  logic [7:0]       cmd_q, crc_q;
  logic [15:0]      addr_q;

  logic       bit_d, len_ok_d;
  logic [7:0] cmd_byte_d, crc_d;
  logic [8:0] len_d;

  always_comb begin
    bit_d      = (low_cnt_q < LVL2);
    cmd_byte_d = {cmd_sh_q, bit_d};
    crc_d      = {crc_q[6:0], bit_d} ^ (crc_q[7] ? 8'h85 : 8'h00);
    len_d      = '1;
    len_ok_d   = 1'b1;
    case (cmd_byte_d)
      8'h00, 8'h01, 8'hFF: len_d = 9'd8;
      8'h02:               len_d = 9'd24;
      8'h03:               len_d = 9'd280;
      default:             len_ok_d = 1'b0;
    endcase
  end

  always_ff @(posedge sample_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      sync1_q       <= 1'b1;
      s_rx_q        <= 1'b1;
      s_prev_q      <= 1'b1;
      hs1_q         <= 1'b0;
      hs2_q         <= 1'b0;
      hcopy_q       <= 1'b0;
      low_cnt_q     <= '0;
      high_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      exp_len_q     <= '1;
      cmd_sh_q      <= '0;
      cur_op_q      <= 1'b0;
      frame_error_q <= 1'b0;
      cmd_q         <= '0;
      crc_q         <= '0;
      addr_q        <= '0;
    end else begin
      sync1_q       <= data_rx;
      s_rx_q        <= sync1_q;
      s_prev_q      <= s_rx_q;
      // rx_handoff is double-registered so release lands three edges after the toggle
      hs1_q         <= rx_handoff;
      hs2_q         <= hs1_q;
      frame_error_q <= 1'b0;
      if (state_q != ST_HANDOFF) hcopy_q <= hs2_q;

      case (state_q)
        ST_IDLE: begin
          if (!s_rx_q && s_prev_q) begin
            state_q   <= ST_LOW;
            low_cnt_q <= CNT_ONE;
            bit_cnt_q <= '0;
            exp_len_q <= '1;
            crc_q     <= '0;
            addr_q    <= '0;
          end
        end

        ST_LOW: begin
          if (s_rx_q) begin
            high_cnt_q <= CNT_ONE;
            if (bit_cnt_q == exp_len_q) begin
              if (bit_d) begin
                state_q  <= ST_HANDOFF;
                cur_op_q <= 1'b1;
              end else begin
                state_q       <= ST_ERROR;
                frame_error_q <= 1'b1;
              end
            end else begin
              state_q <= ST_HIGH;
              if (bit_cnt_q != '1) bit_cnt_q <= bit_cnt_q + 9'd1;
              if (bit_cnt_q < 9'd8) begin
                cmd_sh_q <= cmd_byte_d[6:0];
                if (bit_cnt_q == 9'd7) begin
                  cmd_q     <= cmd_byte_d;
                  exp_len_q <= len_d;
                  if (!len_ok_d) state_q <= ST_DRAIN;
                end
              end else if (bit_cnt_q < 9'd24) begin
                addr_q <= {addr_q[14:0], bit_d};
              end else begin
                crc_q <= crc_d;
              end
            end
          end else if (low_cnt_q >= LOW_TO - CNT_ONE) begin
            state_q       <= ST_ERROR;
            frame_error_q <= 1'b1;
          end else if (low_cnt_q != '1) begin
            low_cnt_q <= low_cnt_q + CNT_ONE;
          end
        end

        ST_HIGH: begin
          if (!s_rx_q) begin
            state_q   <= ST_LOW;
            low_cnt_q <= CNT_ONE;
          end else if (high_cnt_q >= IDLE_TO - CNT_ONE) begin
            state_q       <= ST_ERROR;
            frame_error_q <= 1'b1;
          end else if (high_cnt_q != '1) begin
            high_cnt_q <= high_cnt_q + CNT_ONE;
          end
        end

        // Unknown command: silently wait out the rest of the frame.
        ST_DRAIN: begin
          if (!s_rx_q) begin
            high_cnt_q <= '0;
          end else if (high_cnt_q >= IDLE_TO - CNT_ONE) begin
            state_q <= ST_IDLE;
          end else if (high_cnt_q != '1) begin
            high_cnt_q <= high_cnt_q + CNT_ONE;
          end
        end

        ST_ERROR: begin
          if (s_rx_q) state_q <= ST_IDLE;
        end

        ST_HANDOFF: begin
          if (hs2_q != hcopy_q) begin
            hcopy_q  <= hs2_q;
            cur_op_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cur_operation = cur_op_q;
  assign cmd           = cmd_q;
  assign address       = addr_q;
  assign crc           = crc_q;
  assign frame_error   = frame_error_q;

endmodule

// File: tb/tb_fake_n64_controller_rx.sv
// Self-checking bench for fake_n64_controller_rx: randomized Joybus frames against a frame-level model.
module tb_fake_n64_controller_rx;

  localparam int LW = 2;

  logic        sample_clk = 1'b0;
  logic        reset_n;
  logic        data_rx;
  logic        rx_handoff;
  logic        cur_operation;
  logic [7:0]  cmd;
  logic [15:0] address;
  logic [7:0]  crc;
  logic        frame_error;

  int n_cmp = 0;
  int n_mis = 0;
  int err_cycles = 0;
  int op_cycles = 0;
  bit jitter = 1'b0;
  logic [7:0] pay [32];
  logic frame_q[$];

  fake_n64_controller_rx #(.LEVEL_WIDTH(LW)) dut (
    .sample_clk    (sample_clk),
    .reset_n       (reset_n),
    .data_rx       (data_rx),
    .rx_handoff    (rx_handoff),
    .cur_operation (cur_operation),
    .cmd           (cmd),
    .address       (address),
    .crc           (crc),
    .frame_error   (frame_error)
  );

  always #5 sample_clk = ~sample_clk;

  always @(negedge sample_clk) begin
    if (frame_error === 1'b1) err_cycles++;
    if (cur_operation === 1'b1) op_cycles++;
  end

  function automatic int unsigned model_len(input logic [7:0] c);
    case (c)
      8'h00, 8'h01, 8'hFF: return 8;
      8'h02:               return 24;
      8'h03:               return 280;
      default:             return 0;
    endcase
  endfunction

  function automatic logic [7:0] model_crc();
    logic [7:0] r;
    logic fb;
    r = 8'h00;
    for (int k = 0; k < 32; k++)
      for (int i = 7; i >= 0; i--) begin
        fb = r[7];
        r  = {r[6:0], pay[k][i]} ^ (fb ? 8'h85 : 8'h00);
      end
    return r;
  endfunction

  task automatic build_frame(input logic [7:0] c, input logic [15:0] a);
    int unsigned n;
    n = model_len(c);
    frame_q.delete();
    for (int i = 7; i >= 0; i--) frame_q.push_back(c[i]);
    if (n >= 24) for (int i = 15; i >= 0; i--) frame_q.push_back(a[i]);
    if (n == 280)
      for (int k = 0; k < 32; k++)
        for (int i = 7; i >= 0; i--) frame_q.push_back(pay[k][i]);
  endtask

  task automatic drive_bit(input logic b);
    int unsigned lo, hi;
    if (jitter) begin
      lo = b ? $urandom_range(2*LW-1, 1) : $urandom_range(4*LW, 2*LW);
      hi = $urandom_range(3*LW, 1);
    end else begin
      lo = b ? LW : 3*LW;
      hi = b ? 3*LW : LW;
    end
    data_rx = 1'b0;
    repeat (lo) @(negedge sample_clk);
    data_rx = 1'b1;
    repeat (hi) @(negedge sample_clk);
  endtask

  task automatic run_frame(input logic [7:0] c, input logic [15:0] a, input logic stop, input string tag);
    int unsigned n;
    logic [15:0] eaddr;
    logic [7:0]  ecrc;
    int e0;
    n     = model_len(c);
    eaddr = (n >= 24) ? a : 16'h0000;
    ecrc  = (n == 280) ? model_crc() : 8'h00;
    build_frame(c, a);
    data_rx = 1'b1;
    repeat (4) @(negedge sample_clk);
    e0 = err_cycles;
    foreach (frame_q[i]) drive_bit(frame_q[i]);
    data_rx = 1'b0;
    repeat (stop ? LW : 3*LW) @(negedge sample_clk);
    data_rx = 1'b1;
    repeat (2) @(negedge sample_clk);
    n_cmp++;
    if (cur_operation !== 1'b0) begin n_mis++; $display("FAIL %s cur_op_early: got %b expected 0", tag, cur_operation); end
    @(negedge sample_clk);
    if (stop) begin
      n_cmp++;
      if (cur_operation !== 1'b1) begin n_mis++; $display("FAIL %s cur_op_rise: got %b expected 1", tag, cur_operation); end
      n_cmp++;
      if (cmd !== c) begin n_mis++; $display("FAIL %s cmd: got %h expected %h", tag, cmd, c); end
      n_cmp++;
      if (address !== eaddr) begin n_mis++; $display("FAIL %s address: got %h expected %h", tag, address, eaddr); end
      n_cmp++;
      if (crc !== ecrc) begin n_mis++; $display("FAIL %s crc: got %h expected %h", tag, crc, ecrc); end
      repeat (5) @(negedge sample_clk);
      #1;
      n_cmp++;
      if (cur_operation !== 1'b1 || cmd !== c || address !== eaddr || crc !== ecrc) begin
        n_mis++;
        $display("FAIL %s hold: got op=%b cmd=%h addr=%h crc=%h expected op=1 cmd=%h addr=%h crc=%h",
                 tag, cur_operation, cmd, address, crc, c, eaddr, ecrc);
      end
      n_cmp++;
      if (err_cycles - e0 != 0) begin n_mis++; $display("FAIL %s no_error: got %0d expected 0", tag, err_cycles - e0); end
      @(negedge sample_clk);
      rx_handoff = ~rx_handoff;
      repeat (2) @(negedge sample_clk);
      n_cmp++;
      if (cur_operation !== 1'b1) begin n_mis++; $display("FAIL %s release_early: got %b expected 1", tag, cur_operation); end
      @(negedge sample_clk);
      n_cmp++;
      if (cur_operation !== 1'b0) begin n_mis++; $display("FAIL %s release: got %b expected 0", tag, cur_operation); end
    end else begin
      repeat (6) @(negedge sample_clk);
      #1;
      n_cmp++;
      if (err_cycles - e0 != 1) begin n_mis++; $display("FAIL %s stop0_error: got %0d expected 1", tag, err_cycles - e0); end
      n_cmp++;
      if (cur_operation !== 1'b0) begin n_mis++; $display("FAIL %s stop0_op: got %b expected 0", tag, cur_operation); end
    end
  endtask

  task automatic test_reset();
    reset_n    = 1'b0;
    data_rx    = 1'b1;
    rx_handoff = 1'b0;
    repeat (3) @(negedge sample_clk);
    n_cmp++;
    if (cur_operation !== 1'b0) begin n_mis++; $display("FAIL reset cur_op: got %b expected 0", cur_operation); end
    n_cmp++;
    if (cmd !== 8'h00) begin n_mis++; $display("FAIL reset cmd: got %h expected 00", cmd); end
    n_cmp++;
    if (address !== 16'h0000) begin n_mis++; $display("FAIL reset address: got %h expected 0000", address); end
    n_cmp++;
    if (crc !== 8'h00) begin n_mis++; $display("FAIL reset crc: got %h expected 00", crc); end
    n_cmp++;
    if (frame_error !== 1'b0) begin n_mis++; $display("FAIL reset frame_error: got %b expected 0", frame_error); end
    reset_n = 1'b1;
    repeat (4) @(negedge sample_clk);
  endtask

  task automatic test_status_cmd();
    jitter = 1'b0;
    run_frame(8'h00, 16'h0000, 1'b1, "status");
  endtask

  task automatic test_write();
    jitter = 1'b0;
    for (int k = 0; k < 32; k++) pay[k] = 8'h00;
    run_frame(8'h03, 16'h8001, 1'b1, "write_zero");
    pay[31] = 8'h01;
    run_frame(8'h03, 16'h8001, 1'b1, "write_one");
    jitter = 1'b1;
    for (int t = 0; t < 2; t++) begin
      for (int k = 0; k < 32; k++) pay[k] = 8'($urandom);
      run_frame(8'h03, 16'($urandom), 1'b1, "write_rand");
    end
  endtask

  task automatic test_read();
    jitter = 1'b0;
    run_frame(8'h02, 16'h1234, 1'b1, "read");
    jitter = 1'b1;
    run_frame(8'h02, 16'($urandom), 1'b1, "read_rand");
    run_frame(8'h02, 16'($urandom), 1'b0, "read_stop0");
  endtask

  task automatic test_idle_timeout();
    int e0, o0;
    logic [7:0] c;
    c = 8'h01;
    jitter = 1'b0;
    data_rx = 1'b1;
    repeat (4) @(negedge sample_clk);
    e0 = err_cycles;
    o0 = op_cycles;
    for (int i = 7; i >= 4; i--) drive_bit(c[i]);
    repeat (12) @(negedge sample_clk);
    #1;
    n_cmp++;
    if (err_cycles - e0 != 0) begin n_mis++; $display("FAIL idle_to_early: got %0d expected 0", err_cycles - e0); end
    repeat (10) @(negedge sample_clk);
    #1;
    n_cmp++;
    if (err_cycles - e0 != 1) begin n_mis++; $display("FAIL idle_to_pulse: got %0d expected 1", err_cycles - e0); end
    n_cmp++;
    if (op_cycles - o0 != 0) begin n_mis++; $display("FAIL idle_to_op: got %0d expected 0", op_cycles - o0); end
    jitter = 1'b1;
    run_frame(8'h01, 16'($urandom), 1'b1, "after_idle_to");
  endtask

  task automatic test_bad_cmd();
    int e0, o0;
    logic [7:0] c;
    jitter = 1'b1;
    for (int t = 0; t < 2; t++) begin
      c = 8'h55;
      if (t == 1) begin
        c = 8'($urandom);
        while (model_len(c) != 0) c = 8'($urandom);
      end
      data_rx = 1'b1;
      repeat (4) @(negedge sample_clk);
      e0 = err_cycles;
      o0 = op_cycles;
      for (int i = 7; i >= 0; i--) drive_bit(c[i]);
      repeat (24) @(negedge sample_clk);
      #1;
      n_cmp++;
      if (err_cycles - e0 != 0 || op_cycles - o0 != 0) begin
        n_mis++;
        $display("FAIL bad_cmd %h: got err=%0d op=%0d expected err=0 op=0", c, err_cycles - e0, op_cycles - o0);
      end
    end
    e0 = err_cycles;
    data_rx = 1'b0;
    repeat (31) @(negedge sample_clk);
    data_rx = 1'b1;
    repeat (5) @(negedge sample_clk);
    #1;
    n_cmp++;
    if (err_cycles - e0 != 0) begin n_mis++; $display("FAIL low31: got %0d expected 0", err_cycles - e0); end
    repeat (25) @(negedge sample_clk);
    e0 = err_cycles;
    data_rx = 1'b0;
    repeat (32) @(negedge sample_clk);
    data_rx = 1'b1;
    repeat (6) @(negedge sample_clk);
    #1;
    n_cmp++;
    if (err_cycles - e0 != 1) begin n_mis++; $display("FAIL low32: got %0d expected 1", err_cycles - e0); end
  endtask

  task automatic test_reset_mid_frame();
    logic [15:0] a;
    jitter = 1'b1;
    a = 16'($urandom);
    for (int k = 0; k < 32; k++) pay[k] = 8'($urandom);
    build_frame(8'h03, a);
    data_rx = 1'b1;
    repeat (4) @(negedge sample_clk);
    for (int i = 0; i < 64; i++) drive_bit(frame_q[i]);
    n_cmp++;
    if (cmd !== 8'h03 || address !== a) begin
      n_mis++; $display("FAIL mid_write: got cmd=%h addr=%h expected cmd=03 addr=%h", cmd, address, a);
    end
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({cur_operation, cmd, address, crc, frame_error} !== 34'h0) begin
      n_mis++;
      $display("FAIL mid_reset: got op=%b cmd=%h addr=%h crc=%h err=%b expected all 0",
               cur_operation, cmd, address, crc, frame_error);
    end
    data_rx = 1'b1;
    repeat (2) @(negedge sample_clk);
    reset_n = 1'b1;
    repeat (4) @(negedge sample_clk);
    run_frame(8'hFF, 16'($urandom), 1'b1, "after_reset");

    build_frame(8'h00, 16'h0000);
    foreach (frame_q[i]) drive_bit(frame_q[i]);
    data_rx = 1'b0;
    repeat (LW) @(negedge sample_clk);
    data_rx = 1'b1;
    repeat (4) @(negedge sample_clk);
    n_cmp++;
    if (cur_operation !== 1'b1) begin n_mis++; $display("FAIL ho_before: got %b expected 1", cur_operation); end
    rx_handoff = ~rx_handoff;
    @(negedge sample_clk);
    reset_n = 1'b0;
    #1;
    n_cmp++;
    if (cur_operation !== 1'b0) begin n_mis++; $display("FAIL ho_reset: got %b expected 0", cur_operation); end
    repeat (2) @(negedge sample_clk);
    reset_n = 1'b1;
    repeat (8) @(negedge sample_clk);
    n_cmp++;
    if (cur_operation !== 1'b0) begin n_mis++; $display("FAIL ho_after: got %b expected 0", cur_operation); end
    run_frame(8'h01, 16'($urandom), 1'b1, "after_ho_reset");
  endtask

  task automatic test_back_to_back();
    logic [7:0] tbl [7];
    logic [7:0] c;
    tbl = '{8'h00, 8'h01, 8'hFF, 8'h02, 8'h02, 8'h01, 8'h03};
    jitter = 1'b1;
    for (int t = 0; t < 10; t++) begin
      c = tbl[$urandom_range(6, 0)];
      for (int k = 0; k < 32; k++) pay[k] = 8'($urandom);
      run_frame(c, 16'($urandom), ($urandom_range(5, 0) != 0), "b2b");
    end
  endtask

  initial begin
    test_reset();
    test_status_cmd();
    test_write();
    test_read();
    test_idle_timeout();
    test_bad_cmd();
    test_reset_mid_frame();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/fake_n64_controller_rx.md
# fake_n64_controller_rx

Console-facing receiver of the fake N64 controller. Samples the single Joybus data line, decodes the console's pulse-width-encoded bits, and collects the command byte plus any address and write payload. It also computes the data CRC of a WRITE payload. It then hands the line to `fake_n64_controller_tx` by driving `cur_operation`, `cmd` and `crc`, and takes the line back when the transmitter toggles its `rx_handoff`.

## Interface
- `LEVEL_WIDTH`, 2: sample_clk cycles per Joybus quarter-bit level. `BIT_WIDTH` = 4*`LEVEL_WIDTH`.
- `IDLE_TIMEOUT`, 2*`BIT_WIDTH`: high cycles that abort a frame before the expected bit count is reached.
- `LOW_TIMEOUT`, 4*`BIT_WIDTH`: low cycles that abort a frame (line stuck low).
- `sample_clk`  in  1  sole clock; all state updates on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `data_rx`  in  1  raw Joybus line, idle high; asynchronous to `sample_clk`.
- `rx_handoff`  in  1  toggle from the transmitter; any change means the response is done.
- `cur_operation`  out  1  0 = receiving, 1 = transmitter owns the line.
- `cmd`  out  8  last accepted command byte.
- `address`  out  16  address field of READ/WRITE (0 for other commands).
- `crc`  out  8  data CRC of WRITE payload, unflushed; 0 for other commands.
- `frame_error`  out  1  one-cycle pulse when a frame is discarded.

## Operation
- Reset values: `cur_operation`=0, `cmd`=0, `address`=0, `crc`=0, `frame_error`=0. The 2-flop synchronizer resets to 1, and the stored `rx_handoff` copy is also reset.
- `data_rx` passes through a 2-flop synchronizer. All decoding uses the synchronized value `s_rx`.
- States:
  - IDLE: wait for a falling edge of `s_rx` → MEASURE_LOW, with the low counter at 1.
  - MEASURE_LOW: count low cycles L.
    - On a rising edge, decide the bit: 1 if L < 2*`LEVEL_WIDTH`, else 0. Then → MEASURE_HIGH.
    - If L reaches `LOW_TIMEOUT` → error.
  - MEASURE_HIGH: count high cycles.
    - On a falling edge → MEASURE_LOW.
    - If high count reaches `IDLE_TIMEOUT` → error.
  - HANDOFF: `cur_operation`=1. `s_rx` is ignored. When `rx_handoff` differs from the stored copy, update the copy, set `cur_operation`=0 and go → IDLE.
- Bit assembly is MSB first. The 9-bit bit counter counts decoded bits.
  - Bits 0-7 form the command. After bit 7 the command is latched into `cmd`, which sets the expected data length N:
    - 0x00/0xFF/0x01: N=8.
    - 0x02: N=24.
    - 0x03: N=280.
    - Any other value: abandon the frame silently (no error pulse, no handoff) and go → IDLE once the line has been high for `IDLE_TIMEOUT` cycles.
  - Bits 8-23 shift into `address`.
  - Bits 24-279 (WRITE only) feed the CRC.
    - Per bit b: fb=crc[7]; crc={crc[6:0],b} ^ (fb ? 8'h85 : 8'h00).
    - `crc` clears to 0 at the start of every frame.
  - Bit N is the console stop bit. It must decode as 1.
    - Stop bit = 1: on its rising edge go → HANDOFF.
    - Stop bit = 0: error.
- Error: pulse `frame_error` for one cycle, discard the frame, go → IDLE once `s_rx` is high. `cmd`, `address` and `crc` keep their last values and are not meaningful.
- `cmd`, `address` and `crc` are stable for the whole time `cur_operation`=1.

## Timing
- Synchronizer latency: 2 cycles.
- `cur_operation` rises on the 3rd posedge after the stop bit's rising edge appears on `data_rx`. The transmitter samples on negedge, so outputs are settled half a cycle before first use.
- `cmd` is valid no later than the cycle `cur_operation` rises.
- `cur_operation` falls 3 posedges after the `rx_handoff` toggle.
- Reset asserted mid-frame or mid-handoff: immediate return to IDLE with all outputs at reset values. A pending `rx_handoff` toggle is not acted on.
- A falling edge and a timeout in the same cycle: the edge wins.
- Counters saturate and never wrap.

## Test plan
- Cmd 0x00 at LEVEL_WIDTH=2 (bits encoded low 6/high 2 for 0, low 2/high 6 for 1), plus stop bit → `cmd`=0x00, `cur_operation`=1 three cycles after the stop rise. Toggle `rx_handoff` → `cur_operation`=0 three cycles later.
- Cmd 0x03, address 0x8001, 32 zero bytes, stop → `cmd`=0x03, `address`=0x8001, `crc`=0x00. Same frame with last byte 0x01 → `crc`=0x01.
- Cmd 0x02, address 0x1234 → `address`=0x1234, `crc`=0x00, handoff asserted.
- Cmd 0x01, then line held high for `IDLE_TIMEOUT` after the 4th bit → `frame_error` one cycle, `cur_operation` stays 0. Next valid 0x01 frame is accepted.
- Cmd 0x55 → no `frame_error`, no handoff. Line held low 32 cycles → `frame_error`.
- `reset_n` pulsed low during the WRITE payload → all outputs 0. Following cmd 0xFF frame is accepted normally.
